lfsr_clk_pattern_gen: RTL

// - Upstream source of the slow "LFSR clock" that the edge-capture interrupt PIO samples on its in_port.
// - Divides the 50 MHz system clock into a software-programmable square wave, lfsr_clk.
// - Advances a 5-bit Fibonacci LFSR (x^5+x^3+1) once per lfsr_clk rising edge.
// - Avalon-MM slave: divider, enable and seed are programmable by the HPS/Nios; state is readable.

---
 rtl/lfsr_clk_pattern_gen.sv | 93 +++++++++
 1 files changed

// File: rtl/lfsr_clk_pattern_gen.sv
// Programmable divider producing the slow square wave lfsr_clk, plus a 5-bit
// Fibonacci LFSR (x^5+x^3+1) that advances on each lfsr_clk rising edge.
module lfsr_clk_pattern_gen #(
  parameter logic [31:0] DEFAULT_HALF_PERIOD = 32'd25_000_000,
  parameter logic [4:0]  LFSR_SEED           = 5'b00001,
  parameter logic        ENABLE_AT_RESET     = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        chipselect,
  input  logic [1:0]  address,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        lfsr_clk,
  output logic [4:0]  lfsr_q,
  output logic        lfsr_step
);

  localparam logic [1:0] ADDR_HALF   = 2'd0;
  localparam logic [1:0] ADDR_CTRL   = 2'd1;
  localparam logic [1:0] ADDR_LFSR   = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  logic [31:0] half;
  logic [31:0] cnt;
  logic        enable;

  logic        wr;
  logic        resync;
  logic [31:0] eff_m1;
  logic        terminal;
  logic        rise;
  logic [4:0]  wr_seed;
  logic [4:0]  lfsr_next;
  logic [31:0] rd_mux;

  always_comb begin
    wr        = chipselect & ~write_n;
    resync    = wr && (address == ADDR_CTRL) && writedata[1];
    eff_m1    = (half == 32'd0) ? 32'd0 : half - 32'd1;
    // ">=" lets a newly lowered half wrap immediately instead of overrunning
    terminal  = enable && (cnt >= eff_m1);
    rise      = terminal && !lfsr_clk && !resync;
    // an all-zero LFSR state would lock up, so a zero write loads 1 instead
    wr_seed   = (writedata[4:0] == 5'd0) ? 5'b00001 : writedata[4:0];
    lfsr_next = {lfsr_q[0] ^ lfsr_q[2], lfsr_q[4:1]};

    rd_mux = 32'd0;
    case (address)
      ADDR_HALF:   rd_mux = half;
      ADDR_CTRL:   rd_mux = {31'd0, enable};
      ADDR_LFSR:   rd_mux = {27'd0, lfsr_q};
      ADDR_STATUS: rd_mux = {30'd0, enable, lfsr_clk};
      default:     rd_mux = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      half      <= DEFAULT_HALF_PERIOD;
      enable    <= ENABLE_AT_RESET;
      cnt       <= 32'd0;
      lfsr_clk  <= 1'b0;
      lfsr_q    <= LFSR_SEED;
      lfsr_step <= 1'b0;
      readdata  <= 32'd0;
    end else begin
      readdata  <= rd_mux;
      lfsr_step <= rise;

      if (wr && (address == ADDR_HALF)) half <= writedata;
      if (wr && (address == ADDR_CTRL)) enable <= writedata[0];

      if (resync) begin
        cnt      <= 32'd0;
        lfsr_clk <= 1'b0;
      end else if (enable) begin
        if (terminal) begin
          cnt      <= 32'd0;
          lfsr_clk <= ~lfsr_clk;
        end else begin
          cnt <= cnt + 32'd1;
        end
      end

      // a software seed write takes priority over a coincident step
      if (wr && (address == ADDR_LFSR)) lfsr_q <= wr_seed;
      else if (rise)                    lfsr_q <= lfsr_next;
    end
  end

endmodule
